// File: rtl/noc_arb_pkg.sv
// -----------------------------------------------------------------------------
// noc_arb_pkg
// Shared types and helpers for the router output-port arbiters.
//   arb_state_t : packet-lock FSM state (IDLE = free, LOCK = packet in flight)
//   STALL_W     : width of the optional stall statistics counter
//   rr_next     : wrapped round-robin increment (ptr + 1) mod p
// -----------------------------------------------------------------------------
package noc_arb_pkg;

    typedef enum logic {
        ARB_IDLE = 1'b0,
        ARB_LOCK = 1'b1
    } arb_state_t;

    localparam int STALL_W = 16;

    // Next round-robin position after ptr, wrapping at p.
    function automatic int unsigned rr_next(input int unsigned ptr, input int unsigned p);
        return ((ptr + 32'd1) >= p) ? 32'd0 : (ptr + 32'd1);
    endfunction

endpackage

// File: rtl/noc_rr_pick.sv
// -----------------------------------------------------------------------------
// noc_rr_pick
// Combinational round-robin priority picker. Searches i_req starting at
// i_ptr and wrapping modulo P; the first set request wins.
// Ports:
//   i_req    [P]  request vector
//   i_ptr    [PW] highest-priority index this cycle (must be < P)
//   o_onehot [P]  one-hot winner (all zero when no request)
//   o_idx    [PW] index of the winner (0 when no request)
//   o_valid       at least one request was present
// -----------------------------------------------------------------------------
module noc_rr_pick #(
    parameter int P  = 7,
    parameter int PW = $clog2(P)
) (
    input  logic [P-1:0]  i_req,
    input  logic [PW-1:0] i_ptr,
    output logic [P-1:0]  o_onehot,
    output logic [PW-1:0] o_idx,
    output logic          o_valid
);

    // Wrapped priority search from i_ptr; first hit is kept.
    always_comb begin
        int j;
        o_valid = 1'b0;
        o_idx   = '0;
        for (int k = 0; k < P; k++) begin
            j = int'(i_ptr) + k;
            if (j >= P) begin
                j = j - P;
            end else begin
                j = j;
            end
            if (!o_valid && i_req[j]) begin
                o_valid = 1'b1;
                o_idx   = PW'(j);
            end else begin
                o_valid = o_valid;
            end
        end
        if (o_valid) begin
            o_onehot = {{(P-1){1'b0}}, 1'b1} << o_idx;
        end else begin
            o_onehot = '0;
        end
    end

endmodule

// File: rtl/noc_port_arbiter.sv
// -----------------------------------------------------------------------------
// noc_port_arbiter
// Output-port scheduler for one router link: packet-locked round-robin
// arbitration over P inputs with credit-based flow control toward a B-deep
// downstream buffer.
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   req/req_tail    per-input head-flit valid / head flit is a packet tail
//   req_flit        packed head flits, input i at [FW*(i+1)-1:FW*i]
//   grant           one-hot, combinational; granted input pops this cycle
//   flit_out(_wr)   registered flit and write strobe to downstream
//   credit_in       downstream freed one slot
//   credit_cnt      free downstream slots
//   credit_err      sticky: credit returned while already at B
//   stall_cnt       cycles with requests pending but no credit
// Build option: define NOC_ARB_STATS_EN to implement stall_cnt; otherwise it
// is tied to zero.
// -----------------------------------------------------------------------------
module noc_port_arbiter
    import noc_arb_pkg::*;
#(
    parameter int FW = 36,
    parameter int P  = 7,
    parameter int B  = 4,
    parameter int CW = $clog2(B+1),
    parameter int PW = $clog2(P)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [P-1:0]        req,
    input  logic [P-1:0]        req_tail,
    input  logic [FW*P-1:0]     req_flit,
    output logic [P-1:0]        grant,
    output logic [FW-1:0]       flit_out,
    output logic                flit_out_wr,
    input  logic                credit_in,
    output logic [CW-1:0]       credit_cnt,
    output logic                credit_err,
    output logic [STALL_W-1:0]  stall_cnt
);

    arb_state_t     r_state;
    logic [PW-1:0]  r_ptr;
    logic [PW-1:0]  r_owner;
    logic [CW-1:0]  r_credit;
    logic [FW-1:0]  r_flit_out;
    logic           r_flit_wr;
    logic           r_credit_err;

    logic [P-1:0]   w_pick_onehot;
    logic [PW-1:0]  w_pick_idx;
    logic           w_pick_valid;
    logic [P-1:0]   w_grant;
    logic [PW-1:0]  w_gidx;
    logic           w_gvalid;
    logic           w_gtail;

    noc_rr_pick #(.P(P), .PW(PW)) u_pick (
        .i_req    (req),
        .i_ptr    (r_ptr),
        .o_onehot (w_pick_onehot),
        .o_idx    (w_pick_idx),
        .o_valid  (w_pick_valid)
    );

    // Grant decision: picker result when idle, only the owner while locked.
    always_comb begin
        w_grant  = '0;
        w_gidx   = r_owner;
        w_gvalid = 1'b0;
        if (rst || (r_credit == '0)) begin
            w_gvalid = 1'b0;
        end else if (r_state == ARB_IDLE) begin
            if (w_pick_valid) begin
                w_grant  = w_pick_onehot;
                w_gidx   = w_pick_idx;
                w_gvalid = 1'b1;
            end else begin
                w_gvalid = 1'b0;
            end
        end else begin
            if (req[r_owner]) begin
                w_grant  = {{(P-1){1'b0}}, 1'b1} << r_owner;
                w_gvalid = 1'b1;
            end else begin
                w_gvalid = 1'b0;
            end
        end
        w_gtail = w_gvalid & req_tail[w_gidx];
    end

    // Lock FSM, output flit register and credit counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ARB_IDLE;
            r_ptr        <= '0;
            r_owner      <= '0;
            r_credit     <= CW'(B);
            r_flit_out   <= '0;
            r_flit_wr    <= 1'b0;
            r_credit_err <= 1'b0;
        end else begin
            r_flit_wr <= w_gvalid;
            if (w_gvalid) begin
                r_flit_out <= req_flit[int'(w_gidx)*FW +: FW];
            end

            case (r_state)
                ARB_IDLE: begin
                    if (w_gvalid && !w_gtail) begin
                        r_state <= ARB_LOCK;
                        r_owner <= w_gidx;
                    end else if (w_gvalid) begin
                        r_ptr <= PW'(rr_next(32'(w_gidx), P));
                    end
                end
                ARB_LOCK: begin
                    if (w_gvalid && w_gtail) begin
                        r_state <= ARB_IDLE;
                        r_ptr   <= PW'(rr_next(32'(r_owner), P));
                    end
                end
                default: r_state <= ARB_IDLE;
            endcase

            // A grant and a returned credit in the same cycle cancel out.
            case ({w_gvalid, credit_in})
                2'b10: r_credit <= r_credit - CW'(1);
                2'b01: begin
                    if (r_credit == CW'(B)) begin
                        r_credit_err <= 1'b1;
                    end else begin
                        r_credit <= r_credit + CW'(1);
                    end
                end
                default: r_credit <= r_credit;
            endcase
        end
    end

`ifdef NOC_ARB_STATS_EN
    logic [STALL_W-1:0] r_stall_cnt;

    // Saturating count of cycles blocked purely by lack of credit.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_stall_cnt <= '0;
        end else if ((|req) && (r_credit == '0) && (r_stall_cnt != {STALL_W{1'b1}})) begin
            r_stall_cnt <= r_stall_cnt + STALL_W'(1);
        end
    end

    assign stall_cnt = r_stall_cnt;
`else
    assign stall_cnt = 16'h0;
`endif

    assign grant       = w_grant;
    assign flit_out    = r_flit_out;
    assign flit_out_wr = r_flit_wr;
    assign credit_cnt  = r_credit;
    assign credit_err  = r_credit_err;

endmodule

// File: tb/tb_noc_port_arbiter.sv
// -----------------------------------------------------------------------------
// tb_noc_port_arbiter
// Directed scenarios followed by randomized traffic, checked every cycle
// against a behavioural model of the arbiter (owner/pointer/credit as plain
// integers). Directed steps additionally check constant expectations.
// -----------------------------------------------------------------------------
module tb_noc_port_arbiter;

    localparam int FW = 36;
    localparam int P  = 7;
    localparam int B  = 4;
    localparam int CW = $clog2(B+1);

    logic            clk;
    logic            rst;
    logic [P-1:0]    req;
    logic [P-1:0]    req_tail;
    logic [FW*P-1:0] req_flit;
    logic [P-1:0]    grant;
    logic [FW-1:0]   flit_out;
    logic            flit_out_wr;
    logic            credit_in;
    logic [CW-1:0]   credit_cnt;
    logic            credit_err;
    logic [15:0]     stall_cnt;

    noc_port_arbiter #(.FW(FW), .P(P), .B(B)) dut (
        .clk         (clk),
        .rst         (rst),
        .req         (req),
        .req_tail    (req_tail),
        .req_flit    (req_flit),
        .grant       (grant),
        .flit_out    (flit_out),
        .flit_out_wr (flit_out_wr),
        .credit_in   (credit_in),
        .credit_cnt  (credit_cnt),
        .credit_err  (credit_err),
        .stall_cnt   (stall_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_chk  = 0;
    int n_fail = 0;

    // Reference model state
    int          m_owner;   // -1 when no packet is locked
    int          m_ptr;
    int          m_credit;
    bit          m_err;
    bit          m_wr;
    logic [FW-1:0] m_flit;
    int          m_stall;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_owner  = -1;
        m_ptr    = 0;
        m_credit = B;
        m_err    = 1'b0;
        m_wr     = 1'b0;
        m_flit   = '0;
        m_stall  = 0;
    endtask

    // Which input the rules say is granted right now (-1 = none).
    function automatic int model_grant();
        if (rst || m_credit == 0) return -1;
        if (m_owner >= 0) return req[m_owner] ? m_owner : -1;
        for (int k = 0; k < P; k++) begin
            if (req[(m_ptr + k) % P]) return (m_ptr + k) % P;
        end
        return -1;
    endfunction

    task automatic rand_flits();
        logic [63:0] tmp;
        for (int i = 0; i < P; i++) begin
            tmp = {$urandom, $urandom};
            req_flit[i*FW +: FW] = tmp[FW-1:0];
        end
    endtask

    // One cycle: compare DUT against the model, clock, advance the model.
    task automatic step(input string tag);
        int g;
        logic [P-1:0] exp_grant;
        #1;
        g = model_grant();
        exp_grant = '0;
        if (g >= 0) exp_grant[g] = 1'b1;
        check({tag, ".grant"},   64'(grant),       64'(exp_grant));
        check({tag, ".wr"},      64'(flit_out_wr), 64'(m_wr));
        check({tag, ".flit"},    64'(flit_out),    64'(m_flit));
        check({tag, ".credit"},  64'(credit_cnt),  64'(m_credit));
        check({tag, ".err"},     64'(credit_err),  64'(m_err));
        check({tag, ".stall"},   64'(stall_cnt),   64'(m_stall));
        @(posedge clk);
        if (rst) begin
            model_reset();
        end else begin
`ifdef NOC_ARB_STATS_EN
            if ((|req) && m_credit == 0 && m_stall < 65535) m_stall++;
`endif
            m_wr = (g >= 0);
            if (g >= 0) begin
                m_flit = req_flit[g*FW +: FW];
                if (req_tail[g]) begin
                    m_owner = -1;
                    m_ptr   = (g + 1) % P;
                end else begin
                    m_owner = g;
                end
            end
            if (credit_in && g < 0) begin
                if (m_credit == B) m_err = 1'b1;
                else m_credit++;
            end else if (!credit_in && g >= 0) begin
                m_credit--;
            end
        end
        #1;
    endtask

    task automatic drive(input logic [P-1:0] r, input logic [P-1:0] t, input logic c);
        req = r; req_tail = t; credit_in = c; rand_flits();
    endtask

    task automatic give_credits(input int n);
        for (int i = 0; i < n; i++) begin
            drive(7'b0, 7'b0, 1'b1);
            step("credit_ret");
        end
        credit_in = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        drive(7'b0, 7'b0, 1'b0);
        step("reset");
        rst = 1'b0;
    endtask

    initial begin
        logic [P-1:0] exp_seq [3];
        rst = 1'b1; req = '0; req_tail = '0; req_flit = '0; credit_in = 1'b0;
        @(posedge clk);
        model_reset();
        #1;
        do_reset();
        check("rst.credit", 64'(credit_cnt), 64'(B));
        check("rst.wr",     64'(flit_out_wr), 64'd0);

        // Single-flit contention: grants 0,1,3 then pointer sits at 4.
        exp_seq[0] = 7'b0000001; exp_seq[1] = 7'b0000010; exp_seq[2] = 7'b0001000;
        for (int i = 0; i < 3; i++) begin
            drive(7'b0001011, 7'b1111111, 1'b0);
            #1; check("sf.grant", 64'(grant), 64'(exp_seq[i]));
            step("sf");
            check("sf.wr", 64'(flit_out_wr), 64'd1);
        end
        give_credits(3);
        drive(7'b1111111, 7'b1111111, 1'b0);
        #1; check("sf.ptr4", 64'(grant), 64'(7'b0010000));
        step("sf_ptr");
        give_credits(1);

        // Packet lock: input 2 sends 3 flits while input 5 waits.
        do_reset();
        for (int i = 0; i < 3; i++) begin
            drive(7'b0100100, (i == 2) ? 7'b0100100 : 7'b0100000, 1'b0);
            #1; check("lock.g2", 64'(grant), 64'(7'b0000100));
            step("lock");
        end
        drive(7'b0100000, 7'b0100000, 1'b0);
        #1; check("lock.g5", 64'(grant), 64'(7'b0100000));
        step("lock5");
        give_credits(4);

        // Credit exhaustion: 6 requests, only 4 grants.
        for (int i = 0; i < 6; i++) begin
            drive(7'b0000001, 7'b0000001, 1'b0);
            #1; check("cx.grant", 64'(grant), (i < 4) ? 64'd1 : 64'd0);
            step("cx");
        end
        check("cx.zero", 64'(credit_cnt), 64'd0);
        drive(7'b0000001, 7'b0000001, 1'b1);
        step("cx_ret");
        drive(7'b0000001, 7'b0000001, 1'b0);
        #1; check("cx.regrant", 64'(grant), 64'd1);
        step("cx_g");
        #1; check("cx.zero2", 64'(credit_cnt), 64'd0);
        step("cx_idle");

        // Simultaneous grant + credit at 2, then overflow at B.
        give_credits(2);
        drive(7'b0000001, 7'b0000001, 1'b1);
        step("sim");
        check("sim.credit", 64'(credit_cnt), 64'd2);
        give_credits(2);
        drive(7'b0, 7'b0, 1'b1);
        step("ovf");
        check("ovf.credit", 64'(credit_cnt), 64'(B));
        check("ovf.err",    64'(credit_err), 64'd1);
        drive(7'b0, 7'b0, 1'b0);
        step("ovf_hold");
        check("ovf.sticky", 64'(credit_err), 64'd1);

        // Reset mid-packet abandons the lock.
        do_reset();
        drive(7'b0001000, 7'b0, 1'b0);
        step("mid_head");
        rst = 1'b1;
        drive(7'b0001000, 7'b0, 1'b0);
        #1; check("mid.rstgrant", 64'(grant), 64'd0);
        step("mid_rst");
        rst = 1'b0;
        check("mid.credit", 64'(credit_cnt), 64'(B));
        check("mid.wr",     64'(flit_out_wr), 64'd0);
        drive(7'b0001000, 7'b0001000, 1'b0);
        #1; check("mid.regrant", 64'(grant), 64'(7'b0001000));
        step("mid_g");

        // Stall statistics: 10 cycles of requests with no credit.
        do_reset();
        for (int i = 0; i < 14; i++) begin
            drive(7'b0000001, 7'b0000001, 1'b0);
            step("stall");
        end
`ifdef NOC_ARB_STATS_EN
        check("stall.cnt", 64'(stall_cnt), 64'd10);
`else
        check("stall.cnt", 64'(stall_cnt), 64'd0);
`endif

        // Randomized traffic against the model.
        do_reset();
        for (int i = 0; i < 600; i++) begin
            rst = ($urandom_range(0, 99) == 0);
            drive(7'($urandom_range(0, 127)), 7'($urandom_range(0, 127)),
                  1'($urandom_range(0, 9) < 4));
            step("rand");
        end
        rst = 1'b0;

        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end

endmodule
